// File: rtl/sensor_sdk_reset_seq_pkg.sv
// Shared types and widths for the PLL-driven reset sequencer.
// Optional lock-loss status counter is enabled by SENSOR_SDK_RESET_SEQ_STATUS_EN.
package sensor_sdk_reset_seq_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int LOSS_CNT_W  = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sensor_sdk_sync_2ff.sv
// Parameterized-width two-flop synchronizer; both stages reset to 0.
module sensor_sdk_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // metastability stage followed by the settled stage
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/sensor_sdk_reset_sequencer.sv
// Filters PLL lock and releases NUM_DOMAINS active-low resets in order.
// Define SENSOR_SDK_RESET_SEQ_STATUS_EN to add the lock_loss_count output.
module sensor_sdk_reset_sequencer
    import sensor_sdk_reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int STEP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] rstnn_out,
    output logic                   seq_done,
    output logic [SEQ_STATE_W-1:0] seq_state
`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
    ,
    output logic [LOSS_CNT_W-1:0]  lock_loss_count
`endif
);

    localparam int CNT_W = $clog2(max3(LOCK_FILTER, HOLD_CYCLES, STEP_CYCLES)) + 1;
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]       HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE     = NUM_DOMAINS'(1'b1);

    logic                   lock_s;
    logic                   lock_lost_s;
    logic                   sw_hit_s;
    seq_state_e             state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [IDX_W-1:0]       idx_r, idx_s, idx_nxt_s;
    logic [NUM_DOMAINS-1:0] rout_r, rout_s;
    logic                   done_r, done_s;

    sensor_sdk_sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rstnn (rstnn),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign lock_lost_s = (state_r != ST_WAIT_LOCK) && !lock_s;
    assign sw_hit_s    = sw_reset_req &&
                         ((state_r == ST_HOLD) || (state_r == ST_RELEASE) || (state_r == ST_RUN));
    assign idx_nxt_s   = idx_r + IDX_W'(1);

    // next-state and next-output logic; lock loss outranks a software request
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rout_s  = rout_r;
        done_s  = done_r;
        if (lock_lost_s) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            rout_s  = {NUM_DOMAINS{1'b0}};
            done_s  = 1'b0;
        end else if (sw_hit_s) begin
            state_s = ST_HOLD;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            rout_s  = {NUM_DOMAINS{1'b0}};
            done_s  = 1'b0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    rout_s = {NUM_DOMAINS{1'b0}};
                    done_s = 1'b0;
                    if (lock_s) begin
                        state_s = ST_FILTER;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_FILTER: begin
                    if (cnt_r == FILTER_LAST) begin
                        state_s = ST_HOLD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_s  = {CNT_W{1'b0}};
                        idx_s  = {IDX_W{1'b0}};
                        rout_s = DOM_ONE;
                        // a single domain finishes on the very first release edge
                        if (NUM_DOMAINS == 1) begin
                            state_s = ST_RUN;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == STEP_LAST) begin
                        cnt_s  = {CNT_W{1'b0}};
                        idx_s  = idx_nxt_s;
                        rout_s = rout_r | (DOM_ONE << idx_nxt_s);
                        if (idx_nxt_s == IDX_LAST) begin
                            state_s = ST_RUN;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rout_s = {NUM_DOMAINS{1'b1}};
                    done_s = 1'b1;
                end
                default: begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    rout_s  = {NUM_DOMAINS{1'b0}};
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            rout_r  <= {NUM_DOMAINS{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            rout_r  <= rout_s;
            done_r  <= done_s;
        end
    end

    assign rstnn_out = rout_r;
    assign seq_done  = done_r;
    assign seq_state = state_r;

`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_r;

    // saturating lock-loss event counter, survives software resets
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            loss_cnt_r <= {LOSS_CNT_W{1'b0}};
        end else if (lock_lost_s && (loss_cnt_r != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_count = loss_cnt_r;
`endif

endmodule

// File: tb/tb_sensor_sdk_reset_sequencer.sv
// Directed plus randomized bench for sensor_sdk_reset_sequencer against a timeline model.
module tb_sensor_sdk_reset_sequencer;

    localparam int N  = 3;
    localparam int LF = 16;
    localparam int HC = 64;
    localparam int SC = 8;

    logic         clk = 1'b0;
    logic         rstnn;
    logic         pll_locked;
    logic         sw_reset_req;
    logic [N-1:0] rstnn_out;
    logic         seq_done;
    logic [2:0]   seq_state;
`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
    logic [7:0]   lock_loss_count;
`endif

    always #5 clk = ~clk;

    sensor_sdk_reset_sequencer #(
        .NUM_DOMAINS (N),
        .LOCK_FILTER (LF),
        .HOLD_CYCLES (HC),
        .STEP_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rstnn        (rstnn),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .rstnn_out    (rstnn_out),
        .seq_done     (seq_done),
        .seq_state    (seq_state)
`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Timeline model: a sequence is "armed" from the edge lock is first seen,
    // and el counts edges since then; every output is a threshold on el.
    bit m_s1, m_s2, m_armed;
    int m_el, m_loss, m_arm_edge;
    int edge_no;
    int rise [N];
    int done_rise;

    function automatic void model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_armed = 1'b0;
        m_el = 0; m_loss = 0; m_arm_edge = -1;
    endfunction

    function automatic void model_edge(input bit pll, input bit sw);
        bit ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = pll;
        if (!m_armed) begin
            if (ls) begin
                m_armed = 1'b1; m_el = 0; m_arm_edge = edge_no;
            end
        end else if (!ls) begin
            m_armed = 1'b0;
            if (m_loss < 255) m_loss++;
        end else if (sw && (m_el >= LF)) begin
            m_el = LF;
        end else if (m_el < 1000000) begin
            m_el++;
        end
    endfunction

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_armed && (m_el >= LF + HC + i * SC);
        return v;
    endfunction

    function automatic logic exp_done();
        return m_armed && (m_el >= LF + HC + (N - 1) * SC);
    endfunction

    function automatic logic [2:0] exp_state();
        if (!m_armed) return 3'd0;
        if (m_el < LF) return 3'd1;
        if (m_el < LF + HC) return 3'd2;
        if (m_el < LF + HC + (N - 1) * SC) return 3'd3;
        return 3'd4;
    endfunction

    task automatic check_all();
        total++;
        assert (rstnn_out === exp_out()) else begin
            bad++;
            $error("FAIL rstnn_out edge=%0d got=%b want=%b", edge_no - 1, rstnn_out, exp_out());
        end
        total++;
        assert (seq_done === exp_done()) else begin
            bad++;
            $error("FAIL seq_done edge=%0d got=%b want=%b", edge_no - 1, seq_done, exp_done());
        end
        total++;
        assert (seq_state === exp_state()) else begin
            bad++;
            $error("FAIL seq_state edge=%0d got=%0d want=%0d", edge_no - 1, seq_state, exp_state());
        end
`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
        total++;
        assert (lock_loss_count === 8'(m_loss)) else begin
            bad++;
            $error("FAIL loss_count edge=%0d got=%0d want=%0d", edge_no - 1, lock_loss_count, m_loss);
        end
`endif
    endtask

    // inputs applied at a falling edge, sampled 1 time unit after the rising edge
    task automatic tick(input bit pll, input bit sw);
        pll_locked   = pll;
        sw_reset_req = sw;
        @(posedge clk);
        model_edge(pll, sw);
        edge_no++;
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run_record(input int n);
        for (int i = 0; i < N; i++) rise[i] = -1;
        done_rise = -1;
        for (int k = 0; k < n; k++) begin
            tick(1'b1, 1'b0);
            for (int i = 0; i < N; i++)
                if (rise[i] < 0 && rstnn_out[i]) rise[i] = edge_no - 1;
            if (done_rise < 0 && seq_done) done_rise = edge_no - 1;
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        total++;
        assert (got == want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, g, p, k;
        bit gone;

        rstnn = 1'b0; pll_locked = 1'b1; sw_reset_req = 1'b0;
        model_reset();
        edge_no = 0;
        repeat (3) @(negedge clk);
        check_all();

        // power-up with lock present from the first sampled edge
        rstnn = 1'b1;
        run_record(100);
        check_int("pwr_rise0", rise[0], 82);
        check_int("pwr_rise1", rise[1], 90);
        check_int("pwr_rise2", rise[2], 98);
        check_int("pwr_done", done_rise, 98);

        // software reset from RUN
        tick(1'b1, 1'b1);
        h = edge_no - 1;
        check_int("sw_out_low", int'(rstnn_out), 0);
        check_int("sw_state_hold", int'(seq_state), 2);
        run_record(90);
        check_int("sw_rise0", rise[0] - h, 64);
        check_int("sw_rise1", rise[1] - h, 72);
        check_int("sw_rise2", rise[2] - h, 80);

        // lock loss and software request hit the same edge
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_int("loss_beats_sw", int'(seq_state), 0);

        // one-cycle lock glitch ten cycles into FILTER
        for (int j = 0; j < 30 && !(m_armed && m_el == 10); j++) tick(1'b1, 1'b0);
        check_int("glitch_reached_filter", int'(seq_state), 1);
        g = edge_no;
        tick(1'b0, 1'b0);
        run_record(120);
        check_int("glitch_refiltered", int'(m_arm_edge > g), 1);
        check_int("glitch_rise0", rise[0] - m_arm_edge, 80);

        // lock loss in RUN, then re-lock
        check_int("run_before_loss", int'(seq_state), 4);
        k = 0; gone = 1'b0;
        for (int j = 0; j < 6 && !gone; j++) begin
            tick(1'b0, 1'b0);
            k++;
            if (rstnn_out == '0 && !seq_done) gone = 1'b1;
        end
        check_int("loss_latency", gone ? k : -1, 3);
        check_int("loss_state", int'(seq_state), 0);
        p = edge_no;
        run_record(110);
        check_int("relock_rise0", rise[0] - p, 82);
        check_int("relock_rise2", rise[2] - p, 98);

        // asynchronous reset while the second domain is released
        tick(1'b1, 1'b1);
        for (int j = 0; j < 100 && m_el < LF + HC + SC; j++) tick(1'b1, 1'b0);
        check_int("idx1_pattern", int'(rstnn_out), 3);
        #2;
        rstnn = 1'b0;
        #1;
        model_reset();
        check_int("async_out", int'(rstnn_out), 0);
        check_int("async_done", int'(seq_done), 0);
        check_int("async_state", int'(seq_state), 0);
`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
        check_int("async_loss_cnt", int'(lock_loss_count), 0);
`endif
        @(negedge clk);
        rstnn = 1'b1;

        // randomized lock drops and software requests
        for (int j = 0; j < 4000; j++)
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0));

`ifdef SENSOR_SDK_RESET_SEQ_STATUS_EN
        @(negedge clk);
        rstnn = 1'b0;
        model_reset();
        @(negedge clk);
        rstnn = 1'b1;
        for (int j = 0; j < 300; j++) begin
            repeat (3) tick(1'b1, 1'b0);
            repeat (3) tick(1'b0, 1'b0);
        end
        check_int("loss_saturate", int'(lock_loss_count), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_sdk_reset_sequencer.md
Name: sensor_sdk_reset_sequencer

Overview:
- Controller for the system clock PLL. Filters the PLL lock indication, holds the system in reset while the clock is not trustworthy, then releases NUM_DOMAINS reset outputs in a fixed order with programmable spacing.
- Sits beside the clock PLL wrapper in the platform top, clocked by clk_system. Drives the rstnn of every downstream domain: CPU, interconnect, sensor peripherals.

Parameters:
- NUM_DOMAINS, 3, number of sequenced reset outputs; index 0 releases first; must be >= 1.
- LOCK_FILTER, 16, consecutive synchronized-locked cycles required before lock is accepted; must be >= 1.
- HOLD_CYCLES, 64, cycles all resets stay asserted after lock is accepted or after a software reset; must be >= 1.
- STEP_CYCLES, 8, cycles between successive domain releases; must be >= 1.

Ports:
- clk, input, 1, clk_system from the PLL wrapper.
- rstnn, input, 1, asynchronous active-low reset.
- pll_locked, input, 1, raw PLL lock; asynchronous to clk.
- sw_reset_req, input, 1, single-cycle software reset request; synchronous to clk.
- rstnn_out, output, NUM_DOMAINS, per-domain active-low resets; registered.
- seq_done, output, 1, high while all domains are released (RUN state); registered.
- seq_state, output, 3, current FSM state encoding, for debug.

Behaviour:
- Clock and reset: one clock (clk). Reset (rstnn) is asynchronous, active-low.
- Reset values: rstnn_out = all 0, seq_done = 0, seq_state = WAIT_LOCK, all counters 0, synchronizer flops 0.
- Lock synchronization: pll_locked passes through a 2-flop synchronizer to produce lock_s, which lags pll_locked by 2 cycles.
- States and encodings: WAIT_LOCK=0, FILTER=1, HOLD=2, RELEASE=3, RUN=4. Each counter clears on entry to its state.
- WAIT_LOCK: when lock_s=1, go to FILTER.
- FILTER: counts cycles with lock_s=1.
  - If lock_s=0, return to WAIT_LOCK.
  - When count == LOCK_FILTER-1, go to HOLD. FILTER therefore occupies exactly LOCK_FILTER cycles.
- HOLD: counts HOLD_CYCLES cycles, then goes to RELEASE with idx=0.
- RELEASE: on entry, rstnn_out[0] goes to 1. Every STEP_CYCLES cycles thereafter, idx increments and rstnn_out[idx] goes to 1. Released bits stay 1.
  - The cycle rstnn_out[NUM_DOMAINS-1] rises, seq_done rises and the FSM enters RUN.
  - If NUM_DOMAINS=1, rstnn_out[0] and seq_done rise together on the first RELEASE cycle.
- RUN: steady state; outputs stay all 1.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK means, on the next edge:
  - rstnn_out = 0, seq_done = 0, FSM to WAIT_LOCK.
  - Worst case is 3 cycles from the pll_locked fall to rstnn_out low.
- sw_reset_req:
  - In HOLD, RELEASE or RUN: next edge sets rstnn_out = 0 and seq_done = 0, FSM to HOLD, counter cleared. No lock re-filtering.
  - Ignored in WAIT_LOCK and FILTER.
- Simultaneous lock loss and sw_reset_req: lock loss wins (WAIT_LOCK).
- rstnn asserted mid-sequence: all outputs clear immediately and asynchronously.
- Glitch rule: rstnn_out bits only ever rise in release order. No bit rises outside RELEASE.
- Counter width: $clog2 of max(LOCK_FILTER, HOLD_CYCLES, STEP_CYCLES) + 1. Counters never wrap, because each is cleared on its terminal transition.

Optional Feature:
- Macro: SENSOR_SDK_RESET_SEQ_STATUS_EN.
- When defined: adds output lock_loss_count[7:0].
  - Increments on each lock-loss event that occurs outside WAIT_LOCK.
  - Saturates at 255.
  - Cleared only by rstnn. sw_reset_req does not clear it.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sensor_sdk_reset_seq_pkg holds:
  - the state typedef (3-bit enum, encodings above),
  - SEQ_STATE_W = 3,
  - LOSS_CNT_W = 8.
- Sub-module sensor_sdk_sync_2ff: parameterized-width 2-flop synchronizer with async active-low reset to 0. Used for pll_locked and reusable elsewhere.

Test Plan (default parameters):
1. Power-up: rstnn released, pll_locked held 1 from cycle 0.
   - lock_s rises at cycle 2.
   - rstnn_out[0] rises at cycle 2+16+64 = 82, rstnn_out[1] at 90, rstnn_out[2] at 98.
   - seq_done rises at 98.
2. Lock glitch during filter: pll_locked drops for 1 cycle 10 cycles into FILTER.
   - FSM returns to WAIT_LOCK and refilters.
   - First release occurs 80 cycles after lock_s re-rises; no output rises early.
3. Lock loss in RUN: pll_locked falls.
   - All rstnn_out = 0 and seq_done = 0 within 3 cycles; seq_state = 0.
   - Re-lock repeats the scenario 1 timing.
4. sw_reset_req in RUN: single-cycle pulse.
   - All rstnn_out = 0 the next cycle, seq_state = 2.
   - rstnn_out[0] rises 64 cycles after HOLD entry, then +8 and +16 for the remaining domains.
5. sw_reset_req and pll_locked fall in the same cycle (lock_s=0 at the same edge as the request):
   - FSM goes to WAIT_LOCK, not HOLD.
6. rstnn asserted while idx=1 in RELEASE:
   - rstnn_out = 000 immediately (asynchronous).
   - With SENSOR_SDK_RESET_SEQ_STATUS_EN defined: lock_loss_count = 0 after reset, and 300 lock-loss events give lock_loss_count = 255.
